// File: rtl/hmmm_loader_if.sv
// rtl/hmmm_loader_if.sv - host strobe, readback, program-RAM and CPU control bundle
interface hmmm_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              pgrm_addr;
    logic              pgrm_data;
    logic              pgrm_read;
    logic              pgrm_done;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;
    logic              io_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              cpu_hold;
    logic              cpu_rst;
    logic [ADDR_W:0]   load_count;
    logic              err;

    modport master (
        output pgrm_addr, pgrm_data, pgrm_read, pgrm_done, io_in, mem_rdata,
        input  io_out, io_valid, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, cpu_rst, load_count, err
    );

    modport slave (
        input  pgrm_addr, pgrm_data, pgrm_read, pgrm_done, io_in, mem_rdata,
        output io_out, io_valid, mem_we, mem_addr, mem_wdata,
        output cpu_hold, cpu_rst, load_count, err
    );
endinterface

// File: rtl/hmmm_loader.sv
// rtl/hmmm_loader.sv - host-driven program loader: writes/reads program RAM, holds then resets the CPU
module hmmm_loader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RST_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    hmmm_loader_if.slave bus
);
    localparam int                CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  RCNT_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]       DEPTH_W   = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, READ, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              err_q, err_d;
    logic              clear_pend_q, clear_pend_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              io_valid_q, io_valid_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;

    logic              ptr_wraps;
    logic [ADDR_W-1:0] ptr_inc;
    logic              addr_ok;

    assign ptr_wraps = (ptr_q == PTR_LAST);
    assign ptr_inc   = ptr_wraps ? '0 : ptr_q + ADDR_W'(1);
    assign addr_ok   = ({32'b0, bus.io_in} < {{DATA_W{1'b0}}, DEPTH_W});

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        err_d        = err_q;
        clear_pend_d = clear_pend_q;
        rcnt_d       = rcnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        io_valid_d   = 1'b0;
        io_out_d     = io_out_q;

        case (state_q)
            IDLE, LOAD: begin
                if (bus.pgrm_addr) begin
                    state_d = LOAD;
                    if (addr_ok) begin
                        ptr_d = bus.io_in[ADDR_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.pgrm_data) begin
                    state_d     = LOAD;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = bus.io_in;
                    ptr_d       = ptr_inc;
                    err_d       = err_q | ptr_wraps;
                    clear_pend_d = 1'b0;
                    // The count from the previous load survives release until new data arrives.
                    if (clear_pend_q) begin
                        load_count_d = (ADDR_W + 1)'(1);
                    end else if (load_count_q != CNT_MAX) begin
                        load_count_d = load_count_q + (ADDR_W + 1)'(1);
                    end
                end else if (bus.pgrm_read) begin
                    state_d    = READ;
                    mem_addr_d = ptr_q;
                end else if (bus.pgrm_done && (state_q == LOAD)) begin
                    state_d = RELEASE;
                    rcnt_d  = '0;
                end
            end
            READ: begin
                // First READ cycle presents the address; second one returns RAM data on io_out.
                if (!io_valid_q) begin
                    io_valid_d = 1'b1;
                end else begin
                    state_d  = LOAD;
                    io_out_d = bus.mem_rdata;
                    ptr_d    = ptr_inc;
                    err_d    = err_q | ptr_wraps;
                end
            end
            RELEASE: begin
                if (rcnt_q == RCNT_LAST) begin
                    state_d      = IDLE;
                    ptr_d        = '0;
                    clear_pend_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            load_count_q <= '0;
            err_q        <= 1'b0;
            clear_pend_q <= 1'b0;
            rcnt_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            io_valid_q   <= 1'b0;
            io_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_count_q <= load_count_d;
            err_q        <= err_d;
            clear_pend_q <= clear_pend_d;
            rcnt_q       <= rcnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            io_valid_q   <= io_valid_d;
            io_out_q     <= io_out_d;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.io_valid   = io_valid_q;
    assign bus.io_out     = io_valid_q ? bus.mem_rdata : io_out_q;
    assign bus.cpu_hold   = (state_q != IDLE);
    assign bus.cpu_rst    = (state_q == RELEASE);
    assign bus.load_count = load_count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_hmmm_loader.sv
// tb/tb_hmmm_loader.sv - directed bench with a cycle-indexed event model of the loader
module tb_hmmm_loader;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 256;
    localparam int RST_CYCLES = 2;
    localparam logic [3:0] S_A = 4'b1000, S_D = 4'b0100, S_R = 4'b0010, S_N = 4'b0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hmmm_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hmmm_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: events are scheduled by absolute cycle number from the strobe rules.
    int cyc = 0;
    int m_ptr = 0, m_count = 0, m_busy = 0, m_err_since = 32'h7fffffff;
    int rel_lo = -1, rel_hi = -1;
    bit m_clear = 0, m_loading = 0;
    int m_mem [int];
    int exp_wa [int];
    int exp_wd [int];
    int exp_rd [int];

    task automatic bump(input int at);
        m_ptr = m_ptr + 1;
        if (m_ptr == DEPTH) begin
            m_ptr = 0;
            if (at < m_err_since) m_err_since = at;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_count = 0; m_busy = 0; m_err_since = 32'h7fffffff;
            rel_lo = -1; rel_hi = -1; m_clear = 0; m_loading = 0;
            exp_wa.delete(); exp_wd.delete(); exp_rd.delete();
        end else if (cyc >= m_busy) begin
            if (bus.pgrm_addr) begin
                m_loading = 1;
                if (int'(bus.io_in) < DEPTH) m_ptr = int'(bus.io_in);
                else if (cyc + 1 < m_err_since) m_err_since = cyc + 1;
            end else if (bus.pgrm_data) begin
                m_loading = 1;
                exp_wa[cyc+1] = m_ptr;
                exp_wd[cyc+1] = int'(bus.io_in);
                m_mem[m_ptr]  = int'(bus.io_in);
                m_count = m_clear ? 1 : ((m_count < DEPTH) ? m_count + 1 : DEPTH);
                m_clear = 0;
                bump(cyc + 1);
            end else if (bus.pgrm_read) begin
                m_loading = 1;
                exp_rd[cyc+2] = m_mem.exists(m_ptr) ? m_mem[m_ptr] : 0;
                m_busy = cyc + 3;
                bump(cyc + 3);
            end else if (bus.pgrm_done && m_loading) begin
                m_loading = 0;
                rel_lo = cyc + 1;
                rel_hi = cyc + RST_CYCLES;
                m_busy = cyc + RST_CYCLES + 1;
                m_ptr = 0;
                m_clear = 1;
            end
        end
        cyc++;
    end

    int wr_a[$], wr_d[$], rd_d[$], rd_cyc[$];
    int rst_hi = 0;
    int io_last = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            io_last = 0;
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_io_valid", bus.io_valid, 0);
            chk("rst_io_out", bus.io_out, 0);
            chk("rst_cpu_hold", bus.cpu_hold, 0);
            chk("rst_cpu_rst", bus.cpu_rst, 0);
            chk("rst_load_count", bus.load_count, 0);
            chk("rst_err", bus.err, 0);
        end else begin
            chk("mem_we", bus.mem_we, exp_wa.exists(cyc));
            if (exp_wa.exists(cyc)) begin
                chk("mem_addr", bus.mem_addr, exp_wa[cyc]);
                chk("mem_wdata", bus.mem_wdata, exp_wd[cyc]);
            end
            chk("io_valid", bus.io_valid, exp_rd.exists(cyc));
            if (exp_rd.exists(cyc)) io_last = exp_rd[cyc];
            chk("io_out", bus.io_out, io_last);
            chk("cpu_hold", bus.cpu_hold, m_loading || (cyc < m_busy));
            chk("cpu_rst", bus.cpu_rst, (cyc >= rel_lo) && (cyc <= rel_hi));
            chk("load_count", bus.load_count, m_count);
            chk("err", bus.err, cyc >= m_err_since);
        end
        if (bus.mem_we) begin
            wr_a.push_back(int'(bus.mem_addr));
            wr_d.push_back(int'(bus.mem_wdata));
        end
        if (bus.io_valid) begin
            rd_d.push_back(int'(bus.io_out));
            rd_cyc.push_back(cyc);
        end
        if (bus.cpu_rst) rst_hi++;
    end

    task automatic step(input logic [3:0] s, input logic [DATA_W-1:0] v);
        @(negedge clk);
        #1;
        {bus.pgrm_addr, bus.pgrm_data, bus.pgrm_read, bus.pgrm_done} = s;
        bus.io_in = v;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000, '0);
    endtask

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); rd_d.delete(); rd_cyc.delete();
        rst_hi = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        {bus.pgrm_addr, bus.pgrm_data, bus.pgrm_read, bus.pgrm_done} = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    int sc;

    initial begin
        {bus.pgrm_addr, bus.pgrm_data, bus.pgrm_read, bus.pgrm_done} = 4'b0000;
        bus.io_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_cpu_hold", bus.cpu_hold, 0);
        chk("init_load_count", bus.load_count, 0);
        chk("init_err", bus.err, 0);
        rst_n = 1'b1;

        // Basic load
        clear_logs();
        step(S_A, 16'd0); step(S_D, 16'h112A); step(S_A, 16'd1); step(S_D, 16'h0102);
        step(S_N, '0); idle(5);
        chk("basic_nwr", wr_a.size(), 2);
        chk("basic_wr0_addr", wr_a[0], 0);
        chk("basic_wr0_data", wr_d[0], 32'h112A);
        chk("basic_wr1_addr", wr_a[1], 1);
        chk("basic_wr1_data", wr_d[1], 32'h0102);
        chk("basic_count", bus.load_count, 2);
        chk("basic_rst_len", rst_hi, 2);
        chk("basic_hold_off", bus.cpu_hold, 0);

        // Auto-increment
        clear_logs();
        step(S_A, 16'd5); step(S_D, 16'hA); step(S_D, 16'hB); step(S_D, 16'hC); idle(2);
        chk("inc_nwr", wr_a.size(), 3);
        chk("inc_addr0", wr_a[0], 5);
        chk("inc_addr2", wr_a[2], 7);
        chk("inc_data1", wr_d[1], 32'hB);
        chk("inc_count", bus.load_count, 3);
        chk("inc_err", bus.err, 0);

        // Readback
        clear_logs();
        step(S_A, 16'd5); step(S_R, '0); sc = cyc; idle(4);
        chk("rd_n", rd_d.size(), 1);
        chk("rd_data", rd_d[0], 32'h000A);
        chk("rd_latency", rd_cyc[0] - sc, 2);
        chk("rd_hold_io", bus.io_out, 32'h000A);
        step(S_D, 16'hD); idle(1);
        chk("rd_ptr_next", wr_a[0], 6);

        // Wrap
        clear_logs();
        step(S_A, 16'd255); step(S_D, 16'h1); step(S_D, 16'h2); idle(2);
        chk("wrap_addr0", wr_a[0], 255);
        chk("wrap_addr1", wr_a[1], 0);
        chk("wrap_err", bus.err, 1);

        // Range check
        do_reset();
        clear_logs();
        step(S_A, 16'd3); step(S_A, 16'h0100); step(S_D, 16'h77); idle(2);
        chk("range_err", bus.err, 1);
        chk("range_ptr_kept", wr_a[0], 3);

        // Simultaneous strobes and reads during READ
        clear_logs();
        step(S_A | S_D, 16'd9); idle(1);
        chk("simul_nwr", wr_a.size(), 0);
        step(S_D, 16'h55); idle(1);
        chk("simul_ptr", wr_a[0], 9);
        step(S_A, 16'd9); step(S_R, '0); step(S_R, '0); step(S_R, '0); idle(3);
        chk("rd_busy_n", rd_d.size(), 1);
        chk("rd_busy_data", rd_d[0], 32'h55);

        // Reset mid-release
        clear_logs();
        step(S_N, '0);
        @(negedge clk);
        #1;
        {bus.pgrm_addr, bus.pgrm_data, bus.pgrm_read, bus.pgrm_done} = 4'b0000;
        chk("mid_rel_rst_on", bus.cpu_rst, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rel_rst_off", bus.cpu_rst, 0);
        chk("mid_rel_hold_off", bus.cpu_hold, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_hold", bus.cpu_hold, 0);
        clear_logs();
        step(S_A, 16'd2); step(S_D, 16'h99); idle(1);
        chk("post_rst_wr", wr_a[0], 2);
        chk("post_rst_hold_on", bus.cpu_hold, 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hmmm_loader.md
HMMM_LOADER -- requirements
Module: hmmm_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning bus and program-word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning program-memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of valid words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter RST_CYCLES, default 2, meaning the cpu_rst pulse length in cycles (>= 1).
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is clocked on the rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have ports pgrm_addr, pgrm_data, pgrm_read and pgrm_done, each input, width 1: one-cycle host strobes.
REQ-008 The block SHALL have port io_in, input, width DATA_W: host data or address word, sampled with a strobe.
REQ-009 The block SHALL have port io_out, output, width DATA_W: readback word.
REQ-010 The block SHALL have port io_valid, output, width 1: io_out valid, one-cycle pulse.
REQ-011 The block SHALL have ports mem_we (output, width 1), mem_addr (output, width ADDR_W) and mem_wdata (output, width DATA_W): the program-RAM write/read port.
REQ-012 The block SHALL have port mem_rdata, input, width DATA_W: synchronous-RAM read data, available 1 cycle after mem_addr is presented.
REQ-013 The block SHALL have port cpu_hold, output, width 1: CPU stall while loading.
REQ-014 The block SHALL have port cpu_rst, output, width 1: CPU reset pulse on load completion.
REQ-015 The block SHALL have port load_count, output, width ADDR_W+1: words written since the last release.
REQ-016 The block SHALL have port err, output, width 1: sticky address-range/overflow error flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, READ and RELEASE; cpu_hold SHALL be 1 in LOAD, READ and RELEASE, and 0 in IDLE.
REQ-018 Strobe priority SHALL be pgrm_addr > pgrm_data > pgrm_read > pgrm_done; only the highest-priority asserted strobe SHALL act in a given cycle.
REQ-019 Any of pgrm_addr, pgrm_data or pgrm_read in IDLE SHALL enter LOAD and SHALL also perform its action in the same cycle.
REQ-020 On pgrm_addr, if io_in < DEPTH, the pointer SHALL be loaded from io_in[ADDR_W-1:0]; otherwise the pointer SHALL be unchanged and err SHALL be set.
REQ-021 On pgrm_data in cycle N, mem_we SHALL be 1 in cycle N+1 only, with mem_addr = pointer and mem_wdata = io_in registered at N.
REQ-022 On pgrm_data, the pointer SHALL then increment, and load_count SHALL increment, saturating at DEPTH.
REQ-023 The pointer SHALL wrap from DEPTH-1 to 0, and the wrap SHALL set err.
REQ-024 On pgrm_read in cycle N, the FSM SHALL enter READ, and mem_addr = pointer SHALL be driven at N+1 with mem_we = 0.
REQ-025 For a pgrm_read in cycle N, io_out SHALL equal the captured mem_rdata, and io_valid SHALL be 1, in cycle N+2 only; the FSM SHALL then return to LOAD and the pointer SHALL increment with the same wrap and err rule.
REQ-026 All strobes arriving while in READ SHALL be ignored.
REQ-027 On pgrm_done in LOAD, the FSM SHALL enter RELEASE, and cpu_rst SHALL be 1 for exactly RST_CYCLES cycles, starting the next cycle.
REQ-028 On completion of the cpu_rst pulse, the FSM SHALL go to IDLE with cpu_hold = 0, the pointer = 0, and load_count cleared on the next pgrm_data only.
REQ-029 pgrm_done SHALL be ignored in IDLE, READ and RELEASE.
REQ-030 All strobes SHALL be ignored in RELEASE.
REQ-031 io_out SHALL hold its last value between io_valid pulses.
REQ-032 err SHALL be cleared only by reset.

Reset
REQ-033 While rst = 0, all outputs SHALL be 0 immediately, regardless of clk, including cpu_hold and cpu_rst.
REQ-034 While rst = 0, the FSM SHALL be IDLE, the pointer SHALL be 0, and load_count and err SHALL be 0.
REQ-035 Reset asserted mid-RELEASE or mid-READ SHALL abort without a further mem_we or io_valid.

Verification
REQ-036 Basic load: addr 0, data 0x112A, addr 1, data 0x0102, done -> mem_we pulses (0, 0x112A) and (1, 0x0102); load_count = 2; cpu_rst high 2 cycles; then cpu_hold = 0.
REQ-037 Auto-increment: addr 5, then data 0xA, 0xB, 0xC -> writes at 5, 6, 7; load_count = 3; err = 0.
REQ-038 Readback: after REQ-037, addr 5, then read -> io_valid 2 cycles after the strobe with io_out = 0x000A; the pointer becomes 6.
REQ-039 Wrap and range check: addr 255, data x2 -> writes at 255 then 0, and err = 1. Separately, addr 0x0100 with DEPTH = 256 -> no pointer change, err = 1.
REQ-040 Simultaneous strobes: pgrm_addr and pgrm_data in the same cycle -> pointer loaded and no mem_we. pgrm_read during READ -> single io_valid.
REQ-041 Reset mid-RELEASE: drop rst on the first cpu_rst cycle -> cpu_rst = 0 and cpu_hold = 0 at once; FSM in IDLE after rst rises.
